// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: geometry,
// DMA state encoding and command mode constants.
package mem_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 8;
  localparam int MEM_BYTES = 32768;
  localparam int LEN_W     = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } dma_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Byte counts larger than the memory saturate
  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] l
  );
    if (l > LEN_W'(MEM_BYTES))
      return LEN_W'(MEM_BYTES);
    return l;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// 32 KB byte-wide memory with synchronous read
// and write on we_i.
module mem_ram (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [mem_pkg::ADDR_W-1:0] addr_i,
  input  logic [mem_pkg::DATA_W-1:0] wdata_i,
  output logic [mem_pkg::DATA_W-1:0] rdata_o
);
  import mem_pkg::*;

  logic [DATA_W-1:0] mem_q [MEM_BYTES];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_dma_engine.sv
// Copy/fill bus master for the 32 KB memory,
// driving the memory port one byte per access.
module mem_dma_engine #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_pkg::*;

  dma_state_t        state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   i_q;
  logic [ADDR_W:0]   i_d;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] off;

  assign i_d = i_q + 1'b1;
  assign off = i_q[ADDR_W-1:0];

  // Command FSM; mode is carried by RD/WR vs FILL
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      fill_q  <= '0;
      addr_q  <= '0;
    end else begin
      addr_q <= mem_addr;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= clamp_len(len);
            fill_q <= fill_val;
            i_q    <= '0;
            if (len == '0)
              state_q <= S_DONE;
            else if (mode == MODE_FILL)
              state_q <= S_FILL;
            else
              state_q <= S_RD;
          end
        end
        S_RD: state_q <= S_WR;
        S_WR, S_FILL: begin
          i_q <= i_d;
          if (i_d == len_q)
            state_q <= S_DONE;
          else if (state_q == S_WR)
            state_q <= S_RD;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory port and status decode from state
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = '0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_RD: begin
        mem_addr = src_q + off;
        busy     = 1'b1;
      end
      S_WR: begin
        mem_addr  = dst_q + off;
        mem_wdata = mem_rdata;
        mem_we    = 1'b1;
        busy      = 1'b1;
      end
      S_FILL: begin
        mem_addr  = dst_q + off;
        mem_wdata = fill_q;
        mem_we    = 1'b1;
        busy      = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine driving the
// 32 KB memory; bench can take over the port.
module tb_mem_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [14:0] src;
  logic [14:0] dst;
  logic [15:0] len;
  logic [7:0]  fill_val;
  logic        busy;
  logic        done;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic        own;
  logic        tb_we;
  logic [14:0] tb_addr;
  logic [7:0]  tb_wd;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ram_we   = own ? tb_we   : mem_we;
  assign ram_addr = own ? tb_addr : mem_addr;
  assign ram_wd   = own ? tb_wd   : mem_wdata;

  mem_dma_engine #(.ADDR_W(15), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_ram u_mem (
    .clk(clk), .we_i(ram_we), .addr_i(ram_addr),
    .wdata_i(ram_wd), .rdata_o(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        mode;
    logic [14:0] src;
    logic [14:0] dst;
    logic [15:0] len;
    logic [7:0]  fv;
    int          ecyc;
    int          ebusy;
    int          ewe;
    logic [3:0][14:0] ca;
    logic [3:0][7:0]  cv;
  } vec_t;

  vec_t tbl[5];
  vec_t v;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic mwr(input logic [14:0] a,
                     input logic [7:0] d);
    own = 1'b1;
    tb_addr = a;
    tb_wd = d;
    tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic mrd(input logic [14:0] a,
                     output logic [7:0] d);
    own = 1'b1;
    tb_we = 1'b0;
    tb_addr = a;
    @(posedge clk); #1;
    d = mem_rdata;
  endtask

  // Launch a command at the next edge and measure
  // done latency, busy cycles and write cycles.
  task automatic run_cmd(input vec_t c,
                         input bit inject,
                         output int dcyc,
                         output int bcnt,
                         output int wcnt);
    own = 1'b0;
    mode = c.mode;
    src = c.src;
    dst = c.dst;
    len = c.len;
    fill_val = c.fv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcyc = -1;
    bcnt = 0;
    wcnt = 0;
    for (int k = 1; k <= 40000; k++) begin
      @(negedge clk);
      if (inject && k == 3) begin
        start = 1'b1;
        mode = 1'b1;
        dst = 15'h0010;
        len = 16'd2;
        fill_val = 8'h00;
      end
      if (inject && k == 4) start = 1'b0;
      if (busy) bcnt++;
      if (mem_we) wcnt++;
      if (done) begin
        dcyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({c.name, "_done_1cyc"}, 32'(done), 32'd0);
    chk({c.name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t c, input bit inj);
    int dc, bc, wc;
    logic [7:0] d;
    run_cmd(c, inj, dc, bc, wc);
    chk({c.name, "_done_cyc"}, dc, c.ecyc);
    chk({c.name, "_busy_cnt"}, bc, c.ebusy);
    chk({c.name, "_we_cnt"}, wc, c.ewe);
    for (int j = 0; j < 4; j++) begin
      mrd(c.ca[j], d);
      chk($sformatf("%s_mem%0d", c.name, j),
          32'(d), 32'(c.cv[j]));
    end
  endtask

  initial begin
    logic [7:0] d;
    int nd;

    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    fill_val = '0;
    own = 1'b1;
    tb_we = 1'b0;
    tb_addr = '0;
    tb_wd = '0;

    tbl[0] = '{name:"fill_bank", mode:1'b1,
      src:15'h0, dst:15'h03FE, len:16'd4,
      fv:8'hA5, ecyc:5, ebusy:4, ewe:4,
      ca:{15'h0402, 15'h03FD, 15'h0401, 15'h03FE},
      cv:{8'hEE, 8'hEE, 8'hA5, 8'hA5}};
    tbl[1] = '{name:"copy4", mode:1'b0,
      src:15'h0010, dst:15'h2000, len:16'd4,
      fv:8'h00, ecyc:9, ebusy:8, ewe:4,
      ca:{15'h2003, 15'h2002, 15'h2001, 15'h2000},
      cv:{8'h44, 8'h33, 8'h22, 8'h11}};
    tbl[2] = '{name:"wrap", mode:1'b1,
      src:15'h0, dst:15'h7FFF, len:16'd2,
      fv:8'h5A, ecyc:3, ebusy:2, ewe:2,
      ca:{15'h7FFE, 15'h0001, 15'h0000, 15'h7FFF},
      cv:{8'h77, 8'h77, 8'h5A, 8'h5A}};
    tbl[3] = '{name:"overlap", mode:1'b0,
      src:15'h0100, dst:15'h0101, len:16'd3,
      fv:8'h00, ecyc:7, ebusy:6, ewe:3,
      ca:{15'h0103, 15'h0102, 15'h0101, 15'h0100},
      cv:{8'h01, 8'h01, 8'h01, 8'h01}};
    tbl[4] = '{name:"len0", mode:1'b1,
      src:15'h0, dst:15'h0500, len:16'd0,
      fv:8'hFF, ecyc:1, ebusy:0, ewe:0,
      ca:{15'h0500, 15'h0500, 15'h0500, 15'h0500},
      cv:{8'h33, 8'h33, 8'h33, 8'h33}};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;

    mwr(15'h03FD, 8'hEE);
    mwr(15'h0402, 8'hEE);
    mwr(15'h0010, 8'h11);
    mwr(15'h0011, 8'h22);
    mwr(15'h0012, 8'h33);
    mwr(15'h0013, 8'h44);
    mwr(15'h0014, 8'h55);
    mwr(15'h0015, 8'h66);
    mwr(15'h0016, 8'h77);
    mwr(15'h0017, 8'h88);
    mwr(15'h0001, 8'h77);
    mwr(15'h7FFE, 8'h77);
    mwr(15'h0100, 8'h01);
    mwr(15'h0101, 8'h02);
    mwr(15'h0102, 8'h03);
    mwr(15'h0103, 8'h04);
    mwr(15'h0500, 8'h33);
    mwr(15'h0603, 8'h12);

    for (int k = 0; k < 5; k++)
      run_vec(tbl[k], 1'b0);

    // len=8 copy with a competing start mid-run
    v = '{name:"ign_start", mode:1'b0,
      src:15'h0010, dst:15'h3000, len:16'd8,
      fv:8'h00, ecyc:17, ebusy:16, ewe:8,
      ca:{15'h0011, 15'h3007, 15'h3004, 15'h3000},
      cv:{8'h22, 8'h88, 8'h55, 8'h11}};
    run_vec(v, 1'b1);

    // Reset during the third write of a len=10 fill
    own = 1'b0;
    mode = 1'b1;
    dst = 15'h0600;
    len = 16'd10;
    fill_val = 8'h99;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_3rd_we", 32'(mem_we), 32'd1);
    chk("rstmid_3rd_addr", 32'(mem_addr), 32'h0602);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_we", 32'(mem_we), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("rstmid_no_done", nd, 0);
    @(posedge clk); #1;
    mrd(15'h0602, d);
    chk("rstmid_kept", 32'(d), 32'h99);
    mrd(15'h0603, d);
    chk("rstmid_untouched", 32'(d), 32'h12);
    v = '{name:"after_rst", mode:1'b1,
      src:15'h0, dst:15'h0700, len:16'd1,
      fv:8'h42, ecyc:2, ebusy:1, ewe:1,
      ca:{15'h0700, 15'h0700, 15'h0700, 15'h0700},
      cv:{8'h42, 8'h42, 8'h42, 8'h42}};
    run_vec(v, 1'b0);

    // Oversized length saturates to the full memory
    v = '{name:"clamp", mode:1'b1,
      src:15'h0, dst:15'h0000, len:16'hFFFF,
      fv:8'hC3, ecyc:32769, ebusy:32768,
      ewe:32768,
      ca:{15'h4000, 15'h1234, 15'h7FFF, 15'h0000},
      cv:{8'hC3, 8'hC3, 8'hC3, 8'hC3}};
    run_vec(v, 1'b0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
